// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the pipelined multiplier
//
// Holds the operation encoding carried through the pipeline and the default
// widths used by mul_pipe_unit and mul_stage_reg.

package mul_pkg;

    localparam int MUL_OP_W   = 2;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_PREG_W = 5;
    localparam int DEF_TAG_W  = 5;

    // MUL returns the low half; the three others return the high half with
    // the operand signedness given by the name (MULHSU: signed A, unsigned B).
    typedef enum logic [MUL_OP_W-1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHU  = 2'b10,
        MULHSU = 2'b11
    } mul_op_t;

endpackage

// File: rtl/mul_stage_reg.sv
// rtl/mul_stage_reg.sv - one pipeline slice of the multiplier
//
// Carries valid, op, destination register, ROB tag and the full 2*WIDTH
// product from one stage to the next.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   flush            clear this slice on the next edge (wins over freeze)
//   freeze           hold the slice contents
//   in_*             values from the previous stage
//   out_*            registered values of this stage
//
// Payload fields are forced to zero whenever the slice holds no valid
// operation, so the last slice can drive the unit outputs directly.

module mul_stage_reg
    import mul_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PREG_W = DEF_PREG_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 freeze,
    input  logic                 in_valid,
    input  mul_op_t              in_op,
    input  logic [PREG_W-1:0]    in_pw,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [2*WIDTH-1:0]   in_prod,
    output logic                 out_valid,
    output mul_op_t              out_op,
    output logic [PREG_W-1:0]    out_pw,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2*WIDTH-1:0]   out_prod
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op    <= MUL;
            out_pw    <= '0;
            out_tag   <= '0;
            out_prod  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_op    <= MUL;
            out_pw    <= '0;
            out_tag   <= '0;
            out_prod  <= '0;
        end else if (!freeze) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_op   <= in_op;
                out_pw   <= in_pw;
                out_tag  <= in_tag;
                out_prod <= in_prod;
            end else begin
                out_op   <= MUL;
                out_pw   <= '0;
                out_tag  <= '0;
                out_prod <= '0;
            end
        end
    end

endmodule

// File: rtl/mul_pipe_unit.sv
// rtl/mul_pipe_unit.sv - pipelined integer multiplier with flush and freeze
//
// Forms the full 2*WIDTH product combinationally in front of the first slice,
// carries it with op, Pw and ROB tag through STAGES slices, and picks the
// requested half at the last slice, which doubles as the output register.
// An operation accepted in cycle N is presented in cycle N+STAGES.
//
// Build option: MUL_PIPE_HIGH_EN
//   defined   - MUL, MULH, MULHU and MULHSU are supported
//   undefined - every op returns the low half; no sign extension or high-half
//               selection is built; the port list does not change
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   flush                 drop every in-flight operation (wins over freeze)
//   freeze_back           backend stall, hold all state and ignore inputs
//   valid_mul, op_mul     operation offer and select
//   Pw_mul, tag_ROB_mul   destination register and ROB tag
//   busA_mul, busB_mul    operands
//   valid_Result_mul      result valid
//   Pw_Result_mul         destination register of the result (0 when idle)
//   tag_ROB_Result_mul    ROB tag of the result (0 when idle)
//   Result_mul            selected result half (0 when idle)
//   busy_mul              any operation in flight
//   inflight_mul          number of operations in flight, output included

module mul_pipe_unit
    import mul_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = 2,
    parameter int PREG_W = DEF_PREG_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         freeze_back,
    input  logic                         valid_mul,
    input  logic [MUL_OP_W-1:0]          op_mul,
    input  logic [PREG_W-1:0]            Pw_mul,
    input  logic [TAG_W-1:0]             tag_ROB_mul,
    input  logic [WIDTH-1:0]             busA_mul,
    input  logic [WIDTH-1:0]             busB_mul,
    output logic                         valid_Result_mul,
    output logic [PREG_W-1:0]            Pw_Result_mul,
    output logic [TAG_W-1:0]             tag_ROB_Result_mul,
    output logic [WIDTH-1:0]             Result_mul,
    output logic                         busy_mul,
    output logic [$clog2(STAGES+1)-1:0]  inflight_mul
);

    localparam int CNT_W = $clog2(STAGES + 1);

    // Index 0 is the unregistered input side; index STAGES is the output slice.
    logic                 v_s    [STAGES+1];
    mul_op_t              op_s   [STAGES+1];
    logic [PREG_W-1:0]    pw_s   [STAGES+1];
    logic [TAG_W-1:0]     tag_s  [STAGES+1];
    logic [2*WIDTH-1:0]   prod_s [STAGES+1];

    mul_op_t              op_in;
    logic [2*WIDTH-1:0]   prod_in;
    logic [WIDTH-1:0]     sel_res;
    logic                 accept;
    logic                 leave;

    assign op_in = mul_op_t'(op_mul);

    // ------------------------------------------------------------------
    // Product formation
    // ------------------------------------------------------------------
`ifdef MUL_PIPE_HIGH_EN
    // Extending each operand to 2*WIDTH with its own sign (or zero) makes a
    // plain unsigned 2*WIDTH multiply yield the exact signed, unsigned or
    // mixed product modulo 2^(2*WIDTH), which is all the product we keep.
    logic                 a_sx;
    logic                 b_sx;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;

    always_comb begin
        a_sx  = busA_mul[WIDTH-1] & ((op_in == MULH) | (op_in == MULHSU));
        b_sx  = busB_mul[WIDTH-1] & (op_in == MULH);
        a_ext = {{WIDTH{a_sx}}, busA_mul};
        b_ext = {{WIDTH{b_sx}}, busB_mul};
    end

    assign prod_in = a_ext * b_ext;
`else
    // Only the low half is ever returned, and it is sign-agnostic.
    logic [WIDTH-1:0]     prod_lo;

    assign prod_lo = busA_mul * busB_mul;
    assign prod_in = {{WIDTH{1'b0}}, prod_lo};
`endif

    assign v_s[0]    = valid_mul;
    assign op_s[0]   = op_in;
    assign pw_s[0]   = Pw_mul;
    assign tag_s[0]  = tag_ROB_mul;
    assign prod_s[0] = prod_in;

    // ------------------------------------------------------------------
    // Pipeline slices
    // ------------------------------------------------------------------
    for (genvar i = 1; i <= STAGES; i++) begin : g_stage
        mul_stage_reg #(
            .WIDTH  (WIDTH),
            .PREG_W (PREG_W),
            .TAG_W  (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .freeze    (freeze_back),
            .in_valid  (v_s[i-1]),
            .in_op     (op_s[i-1]),
            .in_pw     (pw_s[i-1]),
            .in_tag    (tag_s[i-1]),
            .in_prod   (prod_s[i-1]),
            .out_valid (v_s[i]),
            .out_op    (op_s[i]),
            .out_pw    (pw_s[i]),
            .out_tag   (tag_s[i]),
            .out_prod  (prod_s[i])
        );
    end

    // ------------------------------------------------------------------
    // Result half selection at the output slice
    // ------------------------------------------------------------------
`ifdef MUL_PIPE_HIGH_EN
    always_comb begin
        sel_res = '0;
        case (op_s[STAGES])
            MUL:     sel_res = prod_s[STAGES][WIDTH-1:0];
            default: sel_res = prod_s[STAGES][2*WIDTH-1:WIDTH];
        endcase
    end
`else
    logic unused_hi;

    assign sel_res   = prod_s[STAGES][WIDTH-1:0];
    assign unused_hi = ^{prod_s[STAGES][2*WIDTH-1:WIDTH], op_s[STAGES]};
`endif

    // The slice already zeroes its payload when idle; the gate keeps the
    // idle-zero guarantee local to the output.
    assign valid_Result_mul   = v_s[STAGES];
    assign Result_mul         = v_s[STAGES] ? sel_res : '0;
    assign Pw_Result_mul      = pw_s[STAGES];
    assign tag_ROB_Result_mul = tag_s[STAGES];

    // ------------------------------------------------------------------
    // In-flight accounting
    // ------------------------------------------------------------------
    assign accept = valid_mul & ~freeze_back & ~flush;
    assign leave  = v_s[STAGES] & ~freeze_back;

    // One accept and one departure per cycle at most, so the count is
    // bounded by the number of slices without extra saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_mul <= '0;
        end else if (flush) begin
            inflight_mul <= '0;
        end else if (accept && !leave) begin
            inflight_mul <= inflight_mul + CNT_W'(1);
        end else if (!accept && leave) begin
            inflight_mul <= inflight_mul - CNT_W'(1);
        end
    end

    assign busy_mul = (inflight_mul != '0);

endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb/tb_mul_pipe_unit.sv - self-checking bench for mul_pipe_unit (STAGES 1, 2, 8)

module tb_mul_pipe_unit;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        freeze_back = 1'b0;
    logic        valid_mul = 1'b0;
    logic [1:0]  op_in = 2'b00;
    logic [4:0]  pw_in = '0;
    logic [4:0]  tag_in = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    typedef struct {
        int          age;
        logic [15:0] res;
        logic [4:0]  pw;
        logic [4:0]  tag;
    } ent_t;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference result straight from the arithmetic definition of each op.
    function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] x,
                                            input logic [15:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint p;
`ifdef MUL_PIPE_HIGH_EN
        case (op)
            2'b00:   p = ux * uy;
            2'b01:   p = sx * sy;
            2'b10:   p = ux * uy;
            default: p = sx * uy;
        endcase
        return (op == 2'b00) ? p[15:0] : p[31:16];
`else
        p = ux * uy;
        return (op == 2'b00 || op != 2'b00) ? p[15:0] : 16'h0;
`endif
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_d
        localparam int S = (k == 0) ? 1 : ((k == 1) ? 2 : 8);

        logic                       vr;
        logic                       busy;
        logic [15:0]                res;
        logic [4:0]                 rpw;
        logic [4:0]                 rtag;
        logic [$clog2(S+1)-1:0]     infl;
        ent_t                       q[$];

        mul_pipe_unit #(
            .WIDTH  (16),
            .STAGES (S),
            .PREG_W (5),
            .TAG_W  (5)
        ) u_dut (
            .clk                (clk),
            .rst                (rst),
            .flush              (flush),
            .freeze_back        (freeze_back),
            .valid_mul          (valid_mul),
            .op_mul             (op_in),
            .Pw_mul             (pw_in),
            .tag_ROB_mul        (tag_in),
            .busA_mul           (a_in),
            .busB_mul           (b_in),
            .valid_Result_mul   (vr),
            .Pw_Result_mul      (rpw),
            .tag_ROB_Result_mul (rtag),
            .Result_mul         (res),
            .busy_mul           (busy),
            .inflight_mul       (infl)
        );

        // Model: each accepted op ages by one per unfrozen edge and is on the
        // outputs while its age equals S; it departs on the next unfrozen edge.
        always @(negedge rst) q.delete();

        always @(posedge clk) begin
            ent_t e;
            if (rst) begin
                if (flush) begin
                    q.delete();
                end else if (!freeze_back) begin
                    if (q.size() > 0 && q[0].age == S) void'(q.pop_front());
                    foreach (q[i]) q[i].age++;
                    if (valid_mul) begin
                        e.age = 1;
                        e.res = ref_res(op_in, a_in, b_in);
                        e.pw  = pw_in;
                        e.tag = tag_in;
                        q.push_back(e);
                    end
                end
            end
        end

        always @(negedge clk) begin
            logic        ev;
            logic [15:0] er;
            logic [4:0]  ep;
            logic [4:0]  et;
            if (chk_en) begin
                ev = (q.size() > 0) && (q[0].age == S);
                er = ev ? q[0].res : 16'h0;
                ep = ev ? q[0].pw  : 5'h0;
                et = ev ? q[0].tag : 5'h0;
                check($sformatf("s%0d_valid", S), 64'(vr), 64'(ev));
                check($sformatf("s%0d_result", S), 64'(res), 64'(er));
                check($sformatf("s%0d_pw", S), 64'(rpw), 64'(ep));
                check($sformatf("s%0d_tag", S), 64'(rtag), 64'(et));
                check($sformatf("s%0d_inflight", S), 64'(infl), 64'(q.size()));
                check($sformatf("s%0d_busy", S), 64'(busy), 64'(q.size() != 0));
                check($sformatf("s%0d_bound", S), 64'(int'(infl) <= S), 64'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic [4:0] p, input logic [4:0] t);
        valid_mul = 1'b1;
        op_in = op; a_in = x; b_in = y; pw_in = p; tag_in = t;
        step();
    endtask

    task automatic idle();
        valid_mul = 1'b0;
        step();
    endtask

    logic [15:0] e_mulh, e_mulhu, e_mul, e_mulhsu;

    initial begin
`ifdef MUL_PIPE_HIGH_EN
        e_mulh = 16'h4000; e_mulhu = 16'hFFFE; e_mul = 16'h0001; e_mulhsu = 16'hFFFF;
`else
        e_mulh = 16'h0000; e_mulhu = 16'h0001; e_mul = 16'h0001; e_mulhsu = 16'hFFFE;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_valid", 64'(g_d[1].vr), 64'd0);
        check("reset_inflight", 64'(g_d[1].infl), 64'd0);
        rst = 1'b1;

        // Basic accept: 3*5 shows up two cycles later on the STAGES=2 unit.
        issue(2'b00, 16'd3, 16'd5, 5'd7, 5'd9);
        idle();
        check("basic_valid", 64'(g_d[1].vr), 64'd1);
        check("basic_result", 64'(g_d[1].res), 64'h000F);
        check("basic_pw", 64'(g_d[1].rpw), 64'd7);
        check("basic_tag", 64'(g_d[1].rtag), 64'd9);
        idle();
        check("basic_after_valid", 64'(g_d[1].vr), 64'd0);
        check("basic_after_result", 64'(g_d[1].res), 64'd0);
        repeat (4) idle();

        // Latency of the 1-stage and 8-stage builds.
        issue(2'b00, 16'd10, 16'd11, 5'd1, 5'd2);
        check("lat1_valid", 64'(g_d[0].vr), 64'd1);
        check("lat1_result", 64'(g_d[0].res), 64'd110);
        for (int c = 2; c <= 8; c++) begin
            idle();
            check($sformatf("lat8_valid_c%0d", c), 64'(g_d[2].vr), 64'(c == 8));
        end
        check("lat8_result", 64'(g_d[2].res), 64'd110);
        repeat (2) idle();

        // Edge-case products, back to back.
        issue(2'b01, 16'h8000, 16'h8000, 5'd1, 5'd1);
        issue(2'b10, 16'hFFFF, 16'hFFFF, 5'd2, 5'd2);
        check("mulh", 64'(g_d[1].res), 64'(e_mulh));
        issue(2'b00, 16'hFFFF, 16'hFFFF, 5'd3, 5'd3);
        check("mulhu", 64'(g_d[1].res), 64'(e_mulhu));
        issue(2'b11, 16'hFFFF, 16'h0002, 5'd4, 5'd4);
        check("mul", 64'(g_d[1].res), 64'(e_mul));
        idle();
        check("mulhsu", 64'(g_d[1].res), 64'(e_mulhsu));
        repeat (8) idle();

        // Three back-to-back accepts, then a 3-cycle freeze with a live offer.
        issue(2'b00, 16'd1, 16'd3, 5'd11, 5'd21);
        issue(2'b00, 16'd2, 16'd3, 5'd12, 5'd22);
        issue(2'b00, 16'd3, 16'd3, 5'd13, 5'd23);
        freeze_back = 1'b1;
        valid_mul = 1'b1; a_in = 16'd7; b_in = 16'd7;
        for (int c = 0; c < 3; c++) begin
            step();
            check("frz_result", 64'(g_d[1].res), 64'd6);
            check("frz_inflight", 64'(g_d[1].infl), 64'd2);
        end
        freeze_back = 1'b0;
        valid_mul = 1'b0;
        step();
        check("frz_release_result", 64'(g_d[1].res), 64'd9);
        check("frz_release_tag", 64'(g_d[1].rtag), 64'd23);
        step();
        check("frz_drained", 64'(g_d[1].infl), 64'd0);
        repeat (8) idle();

        // Flush together with freeze and an offer.
        issue(2'b00, 16'd4, 16'd4, 5'd5, 5'd5);
        issue(2'b00, 16'd5, 16'd5, 5'd6, 5'd6);
        flush = 1'b1; freeze_back = 1'b1; valid_mul = 1'b1;
        step();
        flush = 1'b0; freeze_back = 1'b0; valid_mul = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("flush_valid_%0d", k), 64'(k == 0 ? g_d[0].vr : k == 1 ? g_d[1].vr : g_d[2].vr), 64'd0);
        end
        check("flush_inflight", 64'(g_d[2].infl), 64'd0);
        check("flush_busy", 64'(g_d[1].busy), 64'd0);
        repeat (9) idle();

        // Randomized traffic with occasional freeze and flush.
        for (int c = 0; c < 600; c++) begin
            valid_mul   = ($urandom_range(0, 9) < 7);
            freeze_back = ($urandom_range(0, 9) < 2);
            flush       = ($urandom_range(0, 39) == 0);
            op_in  = 2'($urandom);
            pw_in  = 5'($urandom);
            tag_in = 5'($urandom);
            a_in   = pick16();
            b_in   = pick16();
            step();
        end
        flush = 1'b0; freeze_back = 1'b0;

        // Fill every pipe, then reset asynchronously between edges.
        for (int c = 0; c < 8; c++) issue(2'($urandom), pick16(), pick16(), 5'($urandom), 5'($urandom));
        #2 rst = 1'b0;
        #1;
        check("areset_valid_s8", 64'(g_d[2].vr), 64'd0);
        check("areset_result_s8", 64'(g_d[2].res), 64'd0);
        check("areset_inflight_s8", 64'(g_d[2].infl), 64'd0);
        check("areset_valid_s1", 64'(g_d[0].vr), 64'd0);
        #3 rst = 1'b1;
        // valid_mul is still high: an accept on the first edge after release.
        step();
        check("post_reset_accept", 64'(g_d[1].infl), 64'd1);
        repeat (10) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_pipe_unit.md
MUL_PIPE_UNIT -- requirements
Module: mul_pipe_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 8..32.
REQ-002 Parameter STAGES, default 2: pipeline depth, meaning accept to result in cycles; legal range 1..8.
REQ-003 Parameter PREG_W, default 5: physical destination register tag width.
REQ-004 Parameter TAG_W, default 5: ROB tag width.
REQ-005 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill all in-flight operations.
- freeze_back  in  1  backend stall; hold all state.
- valid_mul  in  1  operation offered.
- op_mul  in  2  operation select.
- Pw_mul  in  PREG_W  destination physical register.
- tag_ROB_mul  in  TAG_W  ROB tag.
- busA_mul  in  WIDTH  operand A.
- busB_mul  in  WIDTH  operand B.
- valid_Result_mul  out  1  result valid.
- Pw_Result_mul  out  PREG_W  destination tag of the result.
- tag_ROB_Result_mul  out  TAG_W  ROB tag of the result.
- Result_mul  out  WIDTH  selected result.
- busy_mul  out  1  at least one stage holds a valid operation.
- inflight_mul  out  $clog2(STAGES+1)  count of valid operations in the pipeline, output register included.

Function
REQ-006 An operation is accepted when valid_mul=1 and freeze_back=0 and flush=0; the unit accepts one operation per cycle and has no backpressure other than freeze_back.
REQ-007 op_mul encoding:
- 00 MUL: low WIDTH bits of the product.
- 01 MULH: high WIDTH bits, signed x signed.
- 10 MULHU: high WIDTH bits, unsigned x unsigned.
- 11 MULHSU: high WIDTH bits, signed A x unsigned B.
REQ-008 The full 2*WIDTH-bit product shall be formed in stage 1; the unit then carries the product with op, Pw and tag through the remaining stages and selects the result half at the final stage.
REQ-009 With no freeze, an operation accepted at cycle N shall appear on the outputs with valid_Result_mul=1 in cycle N+STAGES.
REQ-010 Pw, tag and op shall travel with their operation unchanged; results shall leave in acceptance order.
REQ-011 When valid_Result_mul=0, Result_mul, Pw_Result_mul and tag_ROB_Result_mul shall be 0.
REQ-012 freeze_back=1 and flush=0: every stage and the outputs hold their values, inputs are ignored, and the outputs stay stable for the whole freeze.
REQ-013 flush=1 clears every stage valid bit and every output to 0 on the next edge, whatever freeze_back is; flush has priority over freeze_back.
REQ-014 An operation offered in a flush cycle is dropped.
REQ-015 inflight_mul update per edge:
- increments on accept;
- decrements when a valid result leaves the output register with no freeze;
- is unchanged when both happen in the same cycle;
- becomes 0 on flush;
- never exceeds STAGES.
REQ-016 busy_mul = (inflight_mul != 0).

Reset
REQ-017 rst=0 asynchronously clears all stage registers, all outputs and inflight_mul to 0, including in the middle of an operation.
REQ-018 The first accept is possible in the first cycle after rst deasserts.

Configuration
REQ-019 Macro MUL_PIPE_HIGH_EN:
- Defined: all four ops are supported.
- Undefined: ops 01, 10 and 11 behave as MUL (low half); the sign-extension logic and the high-half path are removed; the port list is unchanged.

Structure
REQ-020 Package mul_pkg shall hold:
- the mul_op_t enum (MUL, MULH, MULHU, MULHSU);
- MUL_OP_W=2;
- the default WIDTH, PREG_W and TAG_W constants.
REQ-021 Sub-module mul_stage_reg: one register slice carrying valid, op, Pw, tag and the 2*WIDTH product, with flush and freeze inputs; mul_pipe_unit instantiates it STAGES times using a generate loop.

Verification
REQ-022 WIDTH=16, STAGES=2; accept op=00, A=3, B=5, Pw=7, tag=9 -> in cycle N+2: valid=1, Result=0x000F, Pw=7, tag=9; outputs 0 in the following cycle.
REQ-023 MULH 0x8000*0x8000 -> 0x4000; MULHU 0xFFFF*0xFFFF -> 0xFFFE; MUL 0xFFFF*0xFFFF -> 0x0001; MULHSU 0xFFFF*0x0002 -> 0xFFFF. With MUL_PIPE_HIGH_EN undefined, all four give the low half.
REQ-024 Three back-to-back accepts, then freeze_back=1 for 3 cycles -> outputs and inflight_mul are frozen and no operation is lost or duplicated; after release the results arrive in order on consecutive cycles.
REQ-025 Two operations in flight, then flush=1 together with freeze_back=1 and valid_mul=1 -> next cycle valid_Result_mul=0, inflight_mul=0, busy_mul=0; no stale result ever appears.
REQ-026 rst=0 pulsed asynchronously between clock edges with the pipe full -> all outputs 0 immediately; STAGES=1 and STAGES=8 builds give results at N+1 and N+8 respectively.
